// File: rtl/reg_l_seq.sv
// reg_l_seq: fixed-priority sequencer driving the L flag register strobes and shift clock.
//
// Ports:
//   clk            processor clock, rising-edge state updates
//   nreset         synchronous reset, active-high (despite the name)
//   req_cll        request: clear L
//   req_cpl        request: complement L
//   req_we         request: load L from IBUS bit 12
//   req_add        request: load L from adder carry
//   req_shift      request: shift sequence of shift_cnt steps
//   shift_cnt      bcp pulse count, 0 means 2**CNT_W; sampled on acceptance
//   ack            one-cycle pulse when a request is accepted
//   busy           high while a sequence is in progress
//   done           one-cycle pulse in the final cycle of a sequence
//   naction_cll    active-low CLL strobe
//   naction_cpl    active-low CPL strobe
//   nflagwe        active-low flag-write strobe
//   nread_alu_add  active-low adder-capture strobe
//   bcp            shift clock, idles high
//
// Optional build macro REG_L_SEQ_ABORT_EN adds:
//   abort          input, stops a shift after the current step completes
//   aborted        output, valid with done, marks an aborted shift
module reg_l_seq #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             req_cll,
    input  logic             req_cpl,
    input  logic             req_we,
    input  logic             req_add,
    input  logic             req_shift,
    input  logic [CNT_W-1:0] shift_cnt,
`ifdef REG_L_SEQ_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             ack,
    output logic             busy,
    output logic             done,
    output logic             naction_cll,
    output logic             naction_cpl,
    output logic             nflagwe,
    output logic             nread_alu_add,
    output logic             bcp
);
    typedef enum logic [1:0] {IDLE, STROBE, SH_LO, SH_HI} state_t;
    localparam logic [CNT_W:0] ONE = 1;
    state_t           state, state_d;
    logic [CNT_W:0]   cnt, cnt_d;
    logic [3:0]       req, nstb_d;
    logic             ack_d, done_d, bcp_d, stop_ab;
    assign req = {req_cll, req_cpl, req_we, req_add};
`ifdef REG_L_SEQ_ABORT_EN
    // An abort seen in SH_HI is remembered so the following step ends the run.
    logic abort_pend, abort_pend_d;
    assign stop_ab      = abort | abort_pend;
    assign abort_pend_d = (state == SH_HI) & ~done & abort;
`else
    assign stop_ab = 1'b0;
`endif
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        nstb_d  = 4'hf;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        bcp_d   = 1'b1;
        case (state)
            IDLE:
                if (|req) begin
                    state_d = STROBE;
                    ack_d   = 1'b1;
                    done_d  = 1'b1;
                    nstb_d  = req[3] ? 4'b0111 : req[2] ? 4'b1011 : req[1] ? 4'b1101 : 4'b1110;
                end else if (req_shift) begin
                    state_d = SH_LO;
                    ack_d   = 1'b1;
                    bcp_d   = 1'b0;
                    // A zero count sets the extra top bit, i.e. 2**CNT_W steps.
                    cnt_d   = {shift_cnt == '0, shift_cnt};
                end
            STROBE: state_d = IDLE;
            SH_LO: begin
                state_d = SH_HI;
                cnt_d   = cnt - ONE;
                done_d  = (cnt == ONE) | stop_ab;
            end
            SH_HI:
                // done was registered on entry to the final SH_HI.
                if (done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = SH_LO;
                    bcp_d   = 1'b0;
                end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (nreset) begin
            state <= IDLE;
            cnt   <= '0;
            ack   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcp   <= 1'b1;
            {naction_cll, naction_cpl, nflagwe, nread_alu_add} <= 4'hf;
`ifdef REG_L_SEQ_ABORT_EN
            abort_pend <= 1'b0;
            aborted    <= 1'b0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            ack   <= ack_d;
            busy  <= state_d != IDLE;
            done  <= done_d;
            bcp   <= bcp_d;
            {naction_cll, naction_cpl, nflagwe, nread_alu_add} <= nstb_d;
`ifdef REG_L_SEQ_ABORT_EN
            abort_pend <= abort_pend_d;
            aborted    <= (state == SH_LO) & stop_ab;
`endif
        end
    end
endmodule

// File: tb/tb_reg_l_seq.sv
// tb_reg_l_seq: directed self-checking bench for reg_l_seq with a small reg_l flag model.
module tb_reg_l_seq;
    logic       clk = 1'b0;
    logic       nreset = 1'b1;
    logic       req_cll = 1'b0, req_cpl = 1'b0, req_we = 1'b0, req_add = 1'b0, req_shift = 1'b0;
    logic [3:0] shift_cnt = 4'd0;
    logic       ack, busy, done, naction_cll, naction_cpl, nflagwe, nread_alu_add, bcp;
    logic       ibus12 = 1'b1, flin_add = 1'b0, fl = 1'b1;
    int         tests = 0, fails = 0, edges = 0, viol = 0;
    int         e0, busy_n, done_n, ack_n, done_at, m, d, seen;
`ifdef REG_L_SEQ_ABORT_EN
    logic abort = 1'b0, aborted;
`endif

    reg_l_seq #(.CNT_W(4)) dut (
        .clk(clk), .nreset(nreset),
        .req_cll(req_cll), .req_cpl(req_cpl), .req_we(req_we), .req_add(req_add),
        .req_shift(req_shift), .shift_cnt(shift_cnt),
`ifdef REG_L_SEQ_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .ack(ack), .busy(busy), .done(done),
        .naction_cll(naction_cll), .naction_cpl(naction_cpl),
        .nflagwe(nflagwe), .nread_alu_add(nread_alu_add), .bcp(bcp)
    );

    always #5 clk = ~clk;

    // Flag register model driven by the strobes.
    always @(posedge clk) begin
        if (!naction_cll) fl <= 1'b0;
        else if (!naction_cpl) fl <= ~fl;
        else if (!nflagwe) fl <= ibus12;
        else if (!nread_alu_add) fl <= flin_add;
    end

    always @(posedge bcp) edges++;

    always @(negedge clk)
        if (int'(!naction_cll) + int'(!naction_cpl) + int'(!nflagwe) + int'(!nread_alu_add) + int'(!bcp) > 1)
            viol++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic single(input string tag, input logic [3:0] r, input logic [3:0] exp_n, input logic exp_fl);
        {req_cll, req_cpl, req_we, req_add} = r;
        tick;
        chk({tag, "_strobe"}, {naction_cll, naction_cpl, nflagwe, nread_alu_add}, exp_n);
        chk({tag, "_ack_done_busy"}, {ack, done, busy}, 3'b111);
        {req_cll, req_cpl, req_we, req_add} = 4'b0;
        tick;
        chk({tag, "_release"}, {naction_cll, naction_cpl, nflagwe, nread_alu_add, ack, busy}, 6'b111100);
        chk({tag, "_fl"}, fl, exp_fl);
    endtask

    task automatic run_shift(input logic [3:0] c, input int exp);
        shift_cnt = c;
        req_shift = 1'b1;
        e0 = edges; busy_n = 0; done_n = 0; ack_n = 0; done_at = 0;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (ack) begin ack_n++; req_shift = 1'b0; end
            if (busy) busy_n++;
            if (done) begin done_n++; done_at = i; end
        end
        chk("shift_edges", edges - e0, exp);
        chk("shift_busy", busy_n, 2 * exp);
        chk("shift_done_cnt", done_n, 1);
        chk("shift_done_at", done_at, 2 * exp);
        chk("shift_ack_cnt", ack_n, 1);
    endtask

    initial begin
        tick; tick;
        chk("reset_outputs", {naction_cll, naction_cpl, nflagwe, nread_alu_add, bcp, ack, busy, done}, 8'b11111000);
        nreset = 1'b0;
        tick;
        single("cll", 4'b1000, 4'b0111, 1'b0);
        single("cpl", 4'b0100, 4'b1011, 1'b1);
        single("we", 4'b0010, 4'b1101, 1'b1);
        single("add", 4'b0001, 4'b1110, 1'b0);
        // Priority: cpl, we, add raised together.
        {req_cpl, req_we, req_add} = 3'b111;
        tick;
        chk("prio1", {naction_cpl, nflagwe, nread_alu_add, ack}, 4'b0111);
        req_cpl = 1'b0;
        tick;
        chk("prio_gap1", {naction_cpl, nflagwe, nread_alu_add, ack}, 4'b1110);
        tick;
        chk("prio2", {naction_cpl, nflagwe, nread_alu_add, ack}, 4'b1011);
        req_we = 1'b0;
        tick;
        chk("prio_gap2", {naction_cpl, nflagwe, nread_alu_add, ack}, 4'b1110);
        tick;
        chk("prio3", {naction_cpl, nflagwe, nread_alu_add, ack}, 4'b1101);
        req_add = 1'b0;
        tick;
        chk("prio_end", {naction_cpl, nflagwe, nread_alu_add, ack, busy}, 5'b11100);
        chk("prio_fl", fl, 1'b0);
        run_shift(4'd3, 3);
        run_shift(4'd0, 16);
        // Ignore requests while busy.
        shift_cnt = 4'd4;
        req_shift = 1'b1;
        tick;
        chk("busy_ack", {ack, bcp}, 2'b10);
        req_shift = 1'b0;
        req_cll = 1'b1;
        m = 0; seen = 0;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (!naction_cll) seen = 1;
            if (done) begin m = i; break; end
        end
        chk("busy_done_at", m, 7);
        chk("busy_no_cll", seen, 0);
        tick;
        chk("busy_after1", {naction_cll, ack}, 2'b10);
        tick;
        chk("busy_after2", {naction_cll, ack}, 2'b01);
        req_cll = 1'b0;
        tick;
        // Reset in the middle of a shift.
        shift_cnt = 4'd5;
        req_shift = 1'b1;
        e0 = edges;
        tick;
        req_shift = 1'b0;
        tick; tick; tick;
        chk("rst_pre_edges", edges - e0, 2);
        nreset = 1'b1;
        d = 0;
        tick;
        chk("rst_outputs", {naction_cll, naction_cpl, nflagwe, nread_alu_add, bcp, busy}, 6'b111110);
        if (done) d++;
        tick;
        if (done) d++;
        tick;
        if (done) d++;
        nreset = 1'b0;
        chk("rst_no_done", d, 0);
        tick;
        chk("rst_idle", {busy, done, bcp}, 3'b001);
        chk("rst_edges", edges - e0, 2);
        chk("rst_fl", fl, 1'b0);
`ifdef REG_L_SEQ_ABORT_EN
        shift_cnt = 4'd8;
        req_shift = 1'b1;
        e0 = edges;
        tick;
        req_shift = 1'b0;
        tick; tick; tick; tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_done", {done, aborted, bcp}, 3'b111);
        chk("abort_edges", edges - e0, 3);
        tick;
        chk("abort_idle", {busy, done, bcp}, 3'b001);
`endif
        chk("mutex", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
